// File: rtl/perm_in_buffer.sv
// Double-buffered chunk assembler feeding the Keccak permutation: fills one bank
// from indexed chunks while the other bank is presented downstream with a tag.
module perm_in_buffer #(
  parameter int CHUNK_W = 200,
  parameter int NCHUNK  = 8,
  parameter int IX_W    = 3,
  parameter int TAG_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pushin,
  input  logic [IX_W-1:0]             dix,
  input  logic [CHUNK_W-1:0]          din,
  output logic                        ready,
  output logic                        pushout,
  input  logic                        take,
  output logic [CHUNK_W*NCHUNK-1:0]   dout,
  output logic [TAG_W-1:0]            tagout,
  output logic                        err_dup,
  output logic                        err_ix,
  output logic                        err_ovf
);

  localparam int STATE_W = CHUNK_W * NCHUNK;
  localparam int unsigned NCH = NCHUNK;
  localparam logic [NCHUNK-1:0] ALL_ONES = '1;
  localparam logic [NCHUNK-1:0] ONE_HOT0 = {{(NCHUNK-1){1'b0}}, 1'b1};

  logic [STATE_W-1:0] bank_data [2];
  logic [NCHUNK-1:0]  bank_mask [2];
  logic [TAG_W-1:0]   bank_tag  [2];
  logic [1:0]         full;
  logic               fp;
  logic               hp;
  logic [TAG_W-1:0]   tag_cnt;

  logic               ix_ok;
  logic               accept;
  logic               dup;
  logic               complete;
  logic               take_ok;
  logic [NCHUNK-1:0]  ix_bit;
  logic [NCHUNK-1:0]  mask_nxt;

  always_comb begin
    ix_ok    = (32'(dix) < NCH);
    ix_bit   = '0;
    if (ix_ok) ix_bit = ONE_HOT0 << dix;
    accept   = pushin & ready & ix_ok;
    dup      = accept & (|(bank_mask[fp] & ix_bit));
    mask_nxt = bank_mask[fp] | ix_bit;
    complete = accept & (mask_nxt == ALL_ONES);
    take_ok  = take & full[hp];
  end

  // Fill side is gated by its own bank; the consumer always sees the head bank.
  assign ready   = ~full[fp];
  assign pushout = full[hp];
  assign dout    = bank_data[hp];
  assign tagout  = bank_tag[hp];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_data[b] <= '0;
        bank_mask[b] <= '0;
        bank_tag[b]  <= '0;
      end
      full    <= '0;
      fp      <= 1'b0;
      hp      <= 1'b0;
      tag_cnt <= '0;
      err_dup <= 1'b0;
      err_ix  <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (accept) begin
        bank_data[fp][int'(dix)*CHUNK_W +: CHUNK_W] <= din;
        bank_mask[fp] <= mask_nxt;
      end
      // Completion and take never target the same bank: completion needs full[fp]=0,
      // an effective take needs full[hp]=1.
      if (complete) begin
        full[fp]      <= 1'b1;
        bank_tag[fp]  <= tag_cnt;
        tag_cnt       <= tag_cnt + 1'b1;
        fp            <= ~fp;
        bank_mask[~fp] <= '0;
      end
      if (take_ok) begin
        full[hp] <= 1'b0;
        hp       <= ~hp;
      end
      if (dup)                   err_dup <= 1'b1;
      if (pushin & ~ix_ok)       err_ix  <= 1'b1;
      if (pushin & ~ready)       err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perm_in_buffer.sv
// Scoreboard bench for perm_in_buffer: randomized and directed chunk traffic against
// a block-level model; a monitor checks every presented state when it is taken.
module tb_perm_in_buffer;

  localparam int CW  = 200;
  localparam int NC  = 8;
  localparam int IXW = 3;
  localparam int TW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             pushin = 1'b0;
  logic [IXW-1:0]   dix = '0;
  logic [CW-1:0]    din = '0;
  logic             take = 1'b0;
  logic             ready, pushout;
  logic [CW*NC-1:0] dout;
  logic [TW-1:0]    tagout;
  logic             err_dup, err_ix, err_ovf;

  perm_in_buffer #(.CHUNK_W(CW), .NCHUNK(NC), .IX_W(IXW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .pushin(pushin), .dix(dix), .din(din),
    .ready(ready), .pushout(pushout), .take(take), .dout(dout), .tagout(tagout),
    .err_dup(err_dup), .err_ix(err_ix), .err_ovf(err_ovf)
  );

  // Small instance with NCHUNK below 2**IX_W to exercise out-of-range indices.
  logic        p6 = 1'b0;
  logic [2:0]  dix6 = '0;
  logic [7:0]  din6 = '0;
  logic        take6 = 1'b0;
  logic        ready6, pushout6;
  logic [47:0] dout6;
  logic [7:0]  tagout6;
  logic        err_dup6, err_ix6, err_ovf6;

  perm_in_buffer #(.CHUNK_W(8), .NCHUNK(6), .IX_W(3), .TAG_W(8)) dut6 (
    .clk(clk), .reset(reset), .pushin(p6), .dix(dix6), .din(din6),
    .ready(ready6), .pushout(pushout6), .take(take6), .dout(dout6), .tagout(tagout6),
    .err_dup(err_dup6), .err_ix(err_ix6), .err_ovf(err_ovf6)
  );

  typedef struct {
    logic [CW*NC-1:0] data;
    logic [TW-1:0]    tag;
  } blk_t;

  blk_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] cur [NC];
  bit            got [NC];
  int            pend = 0;
  logic [TW-1:0] mtag = '0;
  bit            m_dup = 0;
  bit            m_ovf = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd_chunk();
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[CW-33:0], $urandom()};
    return r;
  endfunction

  // Monitor: status every cycle, full state compared whenever a block is consumed.
  always @(negedge clk) begin
    blk_t b;
    if (!reset) begin
      chk("pushout", pushout, exp_q.size() > 0);
      chk("ready", ready, exp_q.size() < 2);
      chk("err_dup", err_dup, m_dup);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_ix", err_ix, 1'b0);
      if (pushout && take && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("tagout", tagout, b.tag);
        for (int k = 0; k < NC; k++)
          chk($sformatf("dout chunk %0d", k), dout[k*CW +: CW], b.data[k*CW +: CW]);
      end
    end
  end

  task automatic clear_block();
    for (int k = 0; k < NC; k++) begin
      got[k] = 0;
      cur[k] = '0;
    end
  endtask

  // One clock of stimulus; the model advances once the edge has happened.
  task automatic cyc(input bit p, input int ix, input logic [CW-1:0] d, input bit t);
    bit   acc, tk, all;
    blk_t b;
    pushin = p;
    dix    = ix[IXW-1:0];
    din    = d;
    take   = t;
    tk  = t && (pend > 0);
    acc = p && (pend < 2);
    @(posedge clk);
    #1;
    if (p && !acc) m_ovf = 1;
    if (tk) pend--;
    if (acc) begin
      if (got[ix]) m_dup = 1;
      cur[ix] = d;
      got[ix] = 1;
      all = 1;
      for (int k = 0; k < NC; k++) if (!got[k]) all = 0;
      if (all) begin
        for (int k = 0; k < NC; k++) b.data[k*CW +: CW] = cur[k];
        b.tag = mtag;
        exp_q.push_back(b);
        mtag++;
        pend++;
        clear_block();
      end
    end
    pushin = 1'b0;
    take   = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pushin = 1'b0;
    take   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    clear_block();
    pend  = 0;
    mtag  = '0;
    m_dup = 0;
    m_ovf = 0;
    chk("rst pushout", pushout, 1'b0);
    chk("rst ready", ready, 1'b1);
    chk("rst dout zero", dout == '0, 1'b1);
    chk("rst tagout", tagout, '0);
    chk("rst errs", {err_dup, err_ix, err_ovf}, 3'b000);
    reset = 1'b0;
  endtask

  int order [8] = '{7, 3, 0, 5, 1, 6, 2, 4};

  initial begin
    do_reset();

    // In-order block, consumer always taking.
    for (int k = 0; k < NC; k++) cyc(1, k, CW'(k), 1);
    cyc(0, 0, '0, 1);

    // Scrambled arrival order.
    for (int i = 0; i < NC; i++) cyc(1, order[i], CW'(order[i] + 16), 1);
    cyc(0, 0, '0, 1);

    // Backpressure: two full banks, then an overflowing push, then drain.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, i % NC, rnd_chunk(), 0);
    repeat (3) cyc(0, 0, '0, 1);

    // Duplicate index overwrites data.
    do_reset();
    cyc(1, 2, CW'(8'hAA), 0);
    cyc(1, 2, CW'(8'hBB), 0);
    for (int k = 0; k < NC; k++) if (k != 2) cyc(1, k, CW'(k + 32), 0);
    cyc(0, 0, '0, 1);

    // Reset in the middle of a block discards it.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1, k, rnd_chunk(), 0);
    do_reset();
    for (int k = NC - 1; k >= 0; k--) cyc(1, k, rnd_chunk(), 0);
    cyc(0, 0, '0, 1);

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, NC - 1), rnd_chunk(),
          $urandom_range(0, 1) == 1);
    for (int i = 0; i < 10 && pend > 0; i++) cyc(0, 0, '0, 1);
    chk("drain pending", pend, 0);

    // Out-of-range index on the six-chunk instance.
    p6 = 1'b1; dix6 = 3'd7; din6 = 8'h5A;
    @(posedge clk); #1;
    p6 = 1'b0;
    chk("n6 err_ix", err_ix6, 1'b1);
    chk("n6 pushout after bad ix", pushout6, 1'b0);
    for (int k = 0; k < 6; k++) begin
      p6 = 1'b1; dix6 = 3'(k); din6 = 8'(k + 1);
      @(posedge clk); #1;
      p6 = 1'b0;
      chk($sformatf("n6 pushout after %0d", k), pushout6, k == 5);
    end
    chk("n6 dout", dout6, 48'h060504030201);
    chk("n6 tagout", tagout6, 8'h00);
    chk("n6 dup/ovf", {err_dup6, err_ovf6}, 2'b00);
    take6 = 1'b1;
    @(posedge clk); #1;
    take6 = 1'b0;
    chk("n6 pushout after take", pushout6, 1'b0);
    chk("n6 ready after take", ready6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
